alu_sequencer: RTL and testbench

Control-side counterpart of the 8-bit combinational ALU. Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4x8 register file. Drives the ALU's A/B/alu_op inputs, captures result and carry, then writes back. Sits between the instruction source (test sequencer or future fetch unit) and the ALU instance.

---
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU: decodes 16-bit instructions, stages
// operands from a 4x8 register file onto the ALU port and writes results back.
module alu_sequencer #(
  parameter int          ALU_LAT   = 1,
  parameter logic [3:0]  RESET_NOP = 4'b0110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  output logic        done,
  output logic        illegal,
  output logic        carry_flag,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   instr_reg;
  logic [7:0]    rf_reg [4];
  logic [7:0]    res_reg;
  logic          carry_cap_reg;
  logic [CW-1:0] cnt_reg;

  logic [3:0] op;
  logic [1:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic       op_undef, op_nop, op_ldi, op_addsub;
  logic       wr_en;
  logic [7:0] wr_data;

  assign op  = instr_reg[15:12];
  assign rd  = instr_reg[11:10];
  assign rs1 = instr_reg[9:8];
  assign rs2 = instr_reg[7:6];
  assign imm = instr_reg[7:0];

  always_comb begin
    op_undef  = 1'b0;
    op_nop    = 1'b0;
    op_ldi    = 1'b0;
    op_addsub = 1'b0;
    case (op)
      4'b0101, 4'b1011, 4'b1101, 4'b1111: op_undef = 1'b1;
      4'b0110:                            op_nop   = 1'b1;
      4'b0011:                            op_ldi   = 1'b1;
      4'b0000, 4'b0001:                   op_addsub = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE: begin
        if (op_undef)               state_next = IDLE;
        else if (op_nop || op_ldi)  state_next = WB;
        else                        state_next = EXEC;
      end
      EXEC:    if (cnt_reg == '0) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign instr_ready = (state_reg == IDLE);
  assign done        = (state_reg == WB);

  // EXEC spans ALU_LAT+1 cycles: operands sit on the port ALU_LAT cycles, and
  // the result is sampled on the final cycle from an already-settled ALU output.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg     <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= RESET_NOP;
      res_reg       <= '0;
      carry_cap_reg <= 1'b0;
      cnt_reg       <= '0;
      illegal       <= 1'b0;
      carry_flag    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state_reg)
        IDLE: if (instr_valid) instr_reg <= instr;
        DECODE: begin
          illegal <= op_undef;
          if (!op_undef && !op_nop && !op_ldi) begin
            alu_a   <= rf_reg[rs1];
            alu_b   <= rf_reg[rs2];
            alu_op  <= op;
            cnt_reg <= CW'(ALU_LAT);
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            res_reg       <= alu_result;
            carry_cap_reg <= alu_carry;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        WB: begin
          if (op_addsub) carry_flag <= carry_cap_reg;
          alu_op <= RESET_NOP;
          alu_a  <= '0;
          alu_b  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign wr_en   = (state_reg == WB) && !op_nop;
  assign wr_data = op_ldi ? imm : res_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (rst)                             rf_reg[gi] <= '0;
        else if (wr_en && rd == 2'(gi))      rf_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign dbg_data = rf_reg[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 8-bit ALU on its port.
module tb_alu_sequencer;
  localparam int ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [1:0]  dbg_sel = '0;
  logic        instr_ready, done, illegal, carry_flag, alu_carry;
  logic [7:0]  alu_a, alu_b, alu_result, dbg_data;
  logic [3:0]  alu_op;

  alu_sequencer #(.ALU_LAT(ALU_LAT), .RESET_NOP(4'b0110)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .done(done),
    .illegal(illegal), .carry_flag(carry_flag), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {carry, result}; SUB carry is the borrow.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b0001: return {1'b0, a} - {1'b0, b};
      4'b0010: return {1'b0, a} + 9'd1;
      4'b0100: return {1'b0, a} - 9'd1;
      4'b1000: return {1'b0, a & b};
      4'b1001: return {1'b0, a | b};
      4'b1010: return {1'b0, ~a};
      4'b1100: return {1'b0, a ^ b};
      4'b1110: return {a, 1'b0};
      4'b0111: return {a[0], 1'b0, a[7:1]};
      default: return 9'd0;
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic       carry;
    int         hs;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_r [4];
  logic       model_c;
  int         compared = 0;
  int         mismatched = 0;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 6'b0};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'b0011, rd, 2'b00, imm};
  endfunction

  task automatic model_push(input logic [15:0] ins, input int hs);
    exp_t       e;
    logic [8:0] r;
    logic [3:0] op = ins[15:12];
    logic [1:0] rd = ins[11:10];
    e.rd = rd;
    e.hs = hs;
    if (op == 4'b0011) begin
      model_r[rd] = ins[7:0];
      e.lat = 2;
    end else if (op == 4'b0110) begin
      e.lat = 2;
    end else begin
      r = alu_f(op, model_r[ins[9:8]], model_r[ins[7:6]]);
      model_r[rd] = r[7:0];
      if (op == 4'b0000 || op == 4'b0001) model_c = r[8];
      e.lat = ALU_LAT + 3;
    end
    e.val   = model_r[rd];
    e.carry = model_c;
    sb.push_back(e);
  endtask

  // Starts and ends just after a falling edge.
  task automatic send(input logic [15:0] ins, input bit hold, input bit track, output int hs);
    bit got = 0;
    hs = -1;
    instr = ins;
    instr_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      if (instr_ready) begin
        got = 1;
        hs = cyc;
        if (track) model_push(ins, hs);
      end
      @(negedge clk);
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout instr=%h ready=%0b required ready=1", ins, instr_ready);
    end
    if (!hold || !got) instr_valid = 1'b0;
  endtask

  task automatic retire();
    exp_t e;
    bit   got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    compared++;
    if (!got || sb.size() == 0) begin
      mismatched++;
      $display("FAIL retire_timeout done=%0b queued=%0d required done=1", done, sb.size());
      return;
    end
    e = sb.pop_front();
    if (cyc - e.hs !== e.lat) begin
      mismatched++;
      $display("FAIL latency rd=%0d got=%0d required=%0d", e.rd, cyc - e.hs, e.lat);
    end
    @(negedge clk);
    dbg_sel = e.rd;
    #1;
    compared++;
    if (dbg_data !== e.val) begin
      mismatched++;
      $display("FAIL wb_data rd=%0d got=%h required=%h", e.rd, dbg_data, e.val);
    end
    compared++;
    if (carry_flag !== e.carry) begin
      mismatched++;
      $display("FAIL carry_flag rd=%0d got=%0b required=%0b", e.rd, carry_flag, e.carry);
    end
    $display("retire rd=%0d data=%h carry=%0b lat=%0d", e.rd, dbg_data, carry_flag, e.lat);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      compared++;
      if (dbg_data !== model_r[i]) begin
        mismatched++;
        $display("FAIL %s R%0d got=%h required=%h", tag, i, dbg_data, model_r[i]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    model_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({instr_ready, done, illegal, carry_flag} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_ctl ready/done/illegal/carry got=%b required=1000",
               {instr_ready, done, illegal, carry_flag});
    end
    compared++;
    if ({alu_op, alu_a, alu_b} !== {4'b0110, 16'h0000}) begin
      mismatched++;
      $display("FAIL reset_alu op=%h a=%h b=%h required op=6 a=0 b=0", alu_op, alu_a, alu_b);
    end
    check_regs("reset_rf");
    $display("reset checked at cycle %0d", cyc);
  endtask

  task automatic test_add();
    int h;
    send(mk_ldi(2'd1, 8'hF0), 0, 1, h); retire();
    send(mk_ldi(2'd2, 8'h20), 0, 1, h); retire();
    send(mk(4'b0000, 2'd3, 2'd1, 2'd2), 0, 1, h); retire();
    dbg_sel = 2'd3;
    #1;
    compared++;
    if ({carry_flag, dbg_data} !== 9'h110) begin
      mismatched++;
      $display("FAIL add_result carry=%0b R3=%h required carry=1 R3=10", carry_flag, dbg_data);
    end
  endtask

  task automatic test_sub_dec();
    int h;
    do_reset();
    send(mk_ldi(2'd0, 8'h05), 0, 1, h); retire();
    send(mk_ldi(2'd1, 8'h07), 0, 1, h); retire();
    send(mk(4'b0001, 2'd2, 2'd0, 2'd1), 0, 1, h); retire();
    send(mk(4'b0100, 2'd3, 2'd3, 2'd0), 0, 1, h); retire();
    dbg_sel = 2'd2;
    #1;
    compared++;
    if (dbg_data !== 8'hFE) begin
      mismatched++;
      $display("FAIL sub_result R2=%h required=FE", dbg_data);
    end
    dbg_sel = 2'd3;
    #1;
    compared++;
    if ({carry_flag, dbg_data} !== 9'h1FF) begin
      mismatched++;
      $display("FAIL dec_result carry=%0b R3=%h required carry=1 R3=FF", carry_flag, dbg_data);
    end
  endtask

  task automatic test_illegal();
    int h;
    int n_ill = 0;
    int ill_cyc = -1;
    bit saw_done = 0;
    bit rdy_ok = 0;
    send(16'hF000, 0, 0, h);
    for (int n = 0; n < 6; n++) begin
      if (done) saw_done = 1;
      if (illegal) begin
        n_ill++;
        ill_cyc = cyc;
      end
      if (cyc == h + 2) rdy_ok = instr_ready;
      @(negedge clk);
    end
    compared++;
    if (n_ill !== 1 || ill_cyc !== h + 2) begin
      mismatched++;
      $display("FAIL illegal_pulse count=%0d at=%0d required count=1 at=%0d", n_ill, ill_cyc, h + 2);
    end
    compared++;
    if (saw_done || !rdy_ok) begin
      mismatched++;
      $display("FAIL illegal_flow done_seen=%0b ready_at_hs+2=%0b required 0/1", saw_done, rdy_ok);
    end
    check_regs("illegal_rf");
    $display("illegal op rejected hs=%0d pulse=%0d", h, ill_cyc);
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    logic [15:0] prog [3];
    prog[0] = mk_ldi(2'd1, 8'h3C);
    prog[1] = mk(4'b0000, 2'd2, 2'd1, 2'd1);
    prog[2] = mk(4'b1110, 2'd3, 2'd2, 2'd0);
    fork
      begin
        int h;
        for (int i = 0; i < 3; i++) send(prog[i], i < 2, 1, h);
      end
      begin
        for (int i = 0; i < 3; i++) retire();
      end
    join
    for (int n = 0; n < 6; n++) begin
      if (done) extra++;
      @(negedge clk);
    end
    compared++;
    if (extra !== 0 || sb.size() !== 0) begin
      mismatched++;
      $display("FAIL b2b_count extra_done=%0d left=%0d required 0/0", extra, sb.size());
    end
    check_regs("b2b_rf");
  endtask

  task automatic test_reset_exec();
    int h;
    int n_done = 0;
    send(mk_ldi(2'd1, 8'h5A), 0, 1, h); retire();
    send(mk_ldi(2'd2, 8'h0F), 0, 1, h); retire();
    send(mk(4'b1100, 2'd0, 2'd1, 2'd2), 0, 0, h);
    @(negedge clk);
    compared++;
    if ({alu_op, alu_a, alu_b} !== {4'b1100, 8'h5A, 8'h0F}) begin
      mismatched++;
      $display("FAIL exec_operands op=%h a=%h b=%h required op=c a=5a b=0f", alu_op, alu_a, alu_b);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    model_c = 1'b0;
    compared++;
    if ({alu_op, instr_ready, carry_flag} !== {4'b0110, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL abort_state op=%h ready=%0b carry=%0b required op=6 ready=1 carry=0",
               alu_op, instr_ready, carry_flag);
    end
    check_regs("abort_rf");
    for (int n = 0; n < 6; n++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    compared++;
    if (n_done !== 0) begin
      mismatched++;
      $display("FAIL abort_done got=%0d required=0", n_done);
    end
    $display("reset during exec hs=%0d", h);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    model_c = 1'b0;
    test_reset();
    test_add();
    test_sub_dec();
    test_illegal();
    test_back_to_back();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
